// File: rtl/ras_ckpt.sv
// Return address stack with circular storage and NUM_CKPT flush-recovery snapshots.
// A restore rewinds pointer and count and repairs the top entry.
module ras_ckpt #(
    parameter int DEPTH    = 8,
    parameter int AW       = 32,
    parameter int NUM_CKPT = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [AW-1:0]               waddr,
    input  logic                        ras_w_en,
    input  logic                        ras_r_en,
    input  logic                        ckpt_en,
    input  logic [$clog2(NUM_CKPT)-1:0] ckpt_id,
    input  logic                        restore_en,
    input  logic [$clog2(NUM_CKPT)-1:0] restore_id,
    output logic [AW-1:0]               raddr,
    output logic                        ras_valid,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_TWO  = PW'(2);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [AW-1:0] entry_r    [DEPTH];
    logic [PW-1:0] w_ptr_r;
    logic [CW-1:0] count_r;
    logic          ras_valid_r;

    logic [PW-1:0] ck_wptr_r  [NUM_CKPT];
    logic [CW-1:0] ck_cnt_r   [NUM_CKPT];
    logic [AW-1:0] ck_top_r   [NUM_CKPT];
    logic [NUM_CKPT-1:0] ck_valid_r;

    logic [PW-1:0] top_idx_s;
    logic [PW-1:0] below_idx_s;
    logic          empty_s;
    logic          wr_en_s;
    logic [PW-1:0] wr_idx_s;
    logic [AW-1:0] wr_data_s;
    logic [PW-1:0] nxt_wptr_s;
    logic [CW-1:0] nxt_cnt_s;
    logic [AW-1:0] nxt_top_s;
    logic          ck_wr_s;

    assign top_idx_s   = w_ptr_r - PTR_ONE;
    assign below_idx_s = w_ptr_r - PTR_TWO;
    assign empty_s     = (count_r == CNT_ZERO);

    assign raddr     = entry_r[top_idx_s];
    assign count     = count_r;
    assign ras_valid = ras_valid_r;

    // Next-state selection: restore beats push/pop; push+pop on an empty stack is a plain push.
    always_comb begin
        wr_en_s    = 1'b0;
        wr_idx_s   = w_ptr_r;
        wr_data_s  = waddr;
        nxt_wptr_s = w_ptr_r;
        nxt_cnt_s  = count_r;
        nxt_top_s  = entry_r[top_idx_s];
        if (restore_en) begin
            if (ck_valid_r[restore_id]) begin
                nxt_wptr_s = ck_wptr_r[restore_id];
                nxt_cnt_s  = ck_cnt_r[restore_id];
                wr_idx_s   = ck_wptr_r[restore_id] - PTR_ONE;
                wr_data_s  = ck_top_r[restore_id];
                wr_en_s    = (ck_cnt_r[restore_id] != CNT_ZERO);
            end else begin
                nxt_wptr_s = PTR_ZERO;
                nxt_cnt_s  = CNT_ZERO;
            end
        end else if (ras_w_en && (!ras_r_en || empty_s)) begin
            wr_en_s    = 1'b1;
            nxt_wptr_s = w_ptr_r + PTR_ONE;
            nxt_cnt_s  = (count_r == CNT_FULL) ? count_r : (count_r + CNT_ONE);
            nxt_top_s  = waddr;
        end else if (ras_w_en) begin
            wr_en_s    = 1'b1;
            wr_idx_s   = top_idx_s;
            nxt_top_s  = waddr;
        end else if (ras_r_en && !empty_s) begin
            nxt_wptr_s = top_idx_s;
            nxt_cnt_s  = count_r - CNT_ONE;
            nxt_top_s  = entry_r[below_idx_s];
        end else begin
            nxt_top_s  = entry_r[top_idx_s];
        end
    end

    assign ck_wr_s = ckpt_en && !restore_en && !reset;

    // Pointer, count and checkpoint-valid state with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_ptr_r     <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            ras_valid_r <= 1'b0;
            ck_valid_r  <= {NUM_CKPT{1'b0}};
        end else begin
            w_ptr_r     <= nxt_wptr_s;
            count_r     <= nxt_cnt_s;
            ras_valid_r <= (nxt_cnt_s != CNT_ZERO);
            if (ck_wr_s) begin
                ck_valid_r[ckpt_id] <= 1'b1;
            end
        end
    end

    // Entry and snapshot payload storage, intentionally not reset.
    always_ff @(posedge clock) begin
        if (wr_en_s && !reset) begin
            entry_r[wr_idx_s] <= wr_data_s;
        end
        if (ck_wr_s) begin
            ck_wptr_r[ckpt_id] <= nxt_wptr_s;
            ck_cnt_r[ckpt_id]  <= nxt_cnt_s;
            ck_top_r[ckpt_id]  <= nxt_top_s;
        end
    end

endmodule
